// File: rtl/threeadder_feeder.sv
// Bit-serial operand feeder for the three-input serial adder: loads three WIDTH-bit words
// and streams them LSB-first as (a,b,c) triples. Define THREEADDER_FEEDER_PAD_EN for two trailing zero pad triples.
module threeadder_feeder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] op_c,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             first,
  output logic             last,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
`ifdef THREEADDER_FEEDER_PAD_EN
  localparam logic [CNT_W-1:0] PAD_LAST = CNT_W'(WIDTH + 1);
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, PAD} state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a, sh_b, sh_c;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sh_a     <= '0;
      sh_b     <= '0;
      sh_c     <= '0;
      cnt      <= '0;
      in_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            sh_a     <= op_a;
            sh_b     <= op_b;
            sh_c     <= op_c;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_ready) begin
            // Zero fill means the registers are already clear when the pad triples go out.
            sh_a <= sh_a >> 1;
            sh_b <= sh_b >> 1;
            sh_c <= sh_c >> 1;
            cnt  <= cnt + 1'b1;
            if (cnt == LAST_BIT) begin
`ifdef THREEADDER_FEEDER_PAD_EN
              state    <= PAD;
`else
              state    <= IDLE;
              in_ready <= 1'b1;
`endif
            end
          end
        end
`ifdef THREEADDER_FEEDER_PAD_EN
        PAD: begin
          if (bit_ready) begin
            cnt <= cnt + 1'b1;
            if (cnt == PAD_LAST) begin
              state    <= IDLE;
              in_ready <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

  // All outputs are decoded from registered state; nothing passes through from inputs.
  assign a         = sh_a[0];
  assign b         = sh_b[0];
  assign c         = sh_c[0];
  assign bit_valid = (state != IDLE);
  assign busy      = (state != IDLE);
  assign first     = (state == SHIFT) && (cnt == '0);
`ifdef THREEADDER_FEEDER_PAD_EN
  assign last      = (state == PAD) && (cnt == PAD_LAST);
`else
  assign last      = (state == SHIFT) && (cnt == LAST_BIT);
`endif

endmodule

// File: doc/threeadder_feeder.md
# threeadder_feeder

Bit-serial operand feeder sitting directly upstream of the three-input serial adder stage. Accepts three WIDTH-bit operands through a valid/ready load handshake, then streams them LSB-first as one bit-triple (a, b, c) per accepted cycle, with first/last framing and downstream back-pressure. It owns the only word-to-bit conversion on the adder input path.

## Interface

- WIDTH, 8, operand width in bits; legal range 2..32.

- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand triple present on op_a/op_b/op_c.
- in_ready  output  1  feeder can accept a triple.
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B.
- op_c  input  WIDTH  operand C.
- a  output  1  current bit of A to the adder.
- b  output  1  current bit of B.
- c  output  1  current bit of C.
- bit_valid  output  1  a/b/c hold a valid bit-triple.
- bit_ready  input  1  adder consumes the triple this cycle.
- first  output  1  triple is bit 0 of the word.
- last  output  1  triple is the final triple of the word.
- busy  output  1  word in flight (state != IDLE).

## Operation

- States: IDLE, SHIFT, PAD (PAD only exists with the macro below).
- IDLE: in_ready=1, bit_valid=0. On in_valid&&in_ready, op_a/op_b/op_c captured into three shift registers, bit counter cleared, go to SHIFT.
- SHIFT: a/b/c = LSB of each shift register; bit_valid=1; first=1 when counter==0; last=1 when counter==WIDTH-1 and PAD not compiled in.
- Transfer occurs on bit_valid&&bit_ready: registers shift right by one (zero fill), counter increments. No transfer: all outputs and state hold unchanged.
- Transfer of bit WIDTH-1: go to IDLE (or PAD when enabled).
- in_valid while busy is ignored; in_ready=0 outside IDLE, so no operand is ever dropped or overwritten.
- in_ready is a function of state only; no combinational path from in_valid or bit_ready to any output except none (all outputs registered or state-decoded).
- Reset values: in_ready=0 during the reset cycle, 1 from the first cycle after reset deasserts; a=b=c=0, bit_valid=0, first=0, last=0, busy=0; shift registers and counter cleared.
- Reset mid-word: word abandoned, return to IDLE next cycle, no further triples issued.

## Timing

- Load accepted in cycle N -> first triple (bit 0) valid in cycle N+1.
- Zero stall: one triple per cycle; word occupies WIDTH cycles (WIDTH+2 with PAD); next load accepted the cycle after last transfer, so back-to-back throughput is one word per WIDTH+1 cycles (WIDTH+3 with PAD).
- Each bit_ready low cycle adds exactly one cycle of latency.
- first and last both valid only alongside bit_valid; first and last are never high together (WIDTH>=2).

## Configuration

- THREEADDER_FEEDER_PAD_EN defined: after bit WIDTH-1, PAD state issues two further triples a=b=c=0 (counter WIDTH, WIDTH+1) so the adder's two-bit carry flushes into sum bits; last asserted on the second pad triple; PAD obeys bit_ready identically to SHIFT.
- Not defined: no PAD state; last on bit WIDTH-1; adder must handle carry-out itself.

## Test plan

- Reset then idle: reset high 2 cycles -> all outputs 0; cycle after release in_ready=1, bit_valid=0.
- Single word, WIDTH=8, op_a=0xA5, op_b=0x0F, op_c=0xFF, bit_ready=1 -> a=1,0,1,0,0,1,0,1; b=1,1,1,1,0,0,0,0; c=1×8; first on cycle 1, last on cycle 8, in_ready=1 on cycle 9.
- Back-pressure: same word, bit_ready low on bits 2 and 5 for 3 cycles each -> outputs frozen while low, identical bit sequence, word completes 6 cycles later.
- Load while busy: in_valid held with new op_a=0x3C during first word -> ignored until IDLE, then accepted; second word streams 0,0,1,1,1,1,0,0 on a.
- Reset mid-word after bit 3 -> next cycle bit_valid=0, busy=0, in_ready=1 following cycle; next load streams from bit 0.
- With THREEADDER_FEEDER_PAD_EN, op_a=op_b=op_c=0xFF -> 8 triples of 1,1,1 then 2 triples of 0,0,0; last only on triple 10.
